axi_llc_tag_port_sched: RTL and testbench

- Owns the single tag-SRAM port of the LLC hit/miss unit and decides who drives it each cycle.
- Requesters are the tag pattern generator (init/March-X BIST), the lookup pipeline and the flush unit.
- Sequences power-up BIST, blocks traffic until it ends, then round-robin arbitrates lookup vs flush.
- Routes read responses back to their originator and supports BIST re-runs on request.

---
 rtl/axi_llc_pkg.sv | 23 ++
 rtl/axi_llc_tag_rsp_pipe.sv | 41 ++++
 rtl/axi_llc_tag_port_sched.sv | 164 ++++++++++++++++
 tb/tb_axi_llc_tag_port_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_pkg.sv
// Shared LLC types: static configuration, tag-port source tags and scheduler states.
package axi_llc_pkg;

    typedef struct packed {
        logic [31:0] SetAssociativity;
        logic [31:0] IndexLength;
    } llc_cfg_t;

    typedef enum logic [1:0] {
        NONE,
        GEN,
        LU,
        FL
    } tag_src_e;

    typedef enum logic [1:0] {
        START,
        BIST,
        OPERATE,
        QUIESCE
    } tag_sched_state_e;

endpackage

// File: rtl/axi_llc_tag_rsp_pipe.sv
// Source-tag delay line matching the tag SRAM read latency; head names the
// requester whose read data is on the SRAM output this cycle.
module axi_llc_tag_rsp_pipe
    import axi_llc_pkg::*;
#(
    parameter int unsigned SramLatency = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  tag_src_e push_src,
    output tag_src_e head_src,
    output logic     empty
);

    tag_src_e stage [SramLatency];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SramLatency; i++) begin
                stage[i] <= NONE;
            end
        end else begin
            stage[0] <= push_src;
            for (int unsigned i = 1; i < SramLatency; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head_src = stage[SramLatency-1];

    always_comb begin
        empty = 1'b1;
        for (int unsigned i = 0; i < SramLatency; i++) begin
            if (stage[i] != NONE) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_llc_tag_port_sched.sv
// Tag SRAM port owner: runs BIST via the pattern generator, then round-robin
// arbitrates lookup and flush, and routes read responses back to their source.
module axi_llc_tag_port_sched
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t    Cfg         = llc_cfg_t'{default: '0},
    parameter type         way_ind_t   = logic,
    parameter type         index_t     = logic,
    parameter type         pattern_t   = logic,
    parameter int unsigned SramLatency = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     bist_start_i,
    output logic     gen_valid_o,
    input  logic     gen_ready_i,
    input  logic     gen_req_i,
    input  logic     gen_we_i,
    input  index_t   gen_index_i,
    input  pattern_t gen_pattern_i,
    input  logic     gen_eoc_i,
    input  way_ind_t gen_bist_res_i,
    output logic     gen_rsp_valid_o,
    input  logic     lu_valid_i,
    input  logic     lu_we_i,
    output logic     lu_ready_o,
    input  way_ind_t lu_way_i,
    input  index_t   lu_index_i,
    input  pattern_t lu_pattern_i,
    output logic     lu_rsp_valid_o,
    input  logic     fl_valid_i,
    input  logic     fl_we_i,
    output logic     fl_ready_o,
    input  way_ind_t fl_way_i,
    input  index_t   fl_index_i,
    input  pattern_t fl_pattern_i,
    output logic     fl_rsp_valid_o,
    output way_ind_t sram_req_o,
    output logic     sram_we_o,
    output index_t   sram_index_o,
    output pattern_t sram_wdata_o,
    output logic     init_done_o,
    output way_ind_t spm_ways_o
);

    localparam int unsigned Ways = (Cfg.SetAssociativity == 32'd0) ?
                                   $bits(way_ind_t) : 32'(Cfg.SetAssociativity);

    tag_sched_state_e state;
    tag_src_e         rr;
    tag_src_e         push_src;
    tag_src_e         head_src;
    logic             pipe_empty;

    always_comb begin
        gen_valid_o  = 1'b0;
        lu_ready_o   = 1'b0;
        fl_ready_o   = 1'b0;
        sram_req_o   = '0;
        sram_we_o    = 1'b0;
        sram_index_o = '0;
        sram_wdata_o = '0;
        push_src     = NONE;
        case (state)
            START: begin
                gen_valid_o = gen_ready_i;
            end
            BIST: begin
                sram_req_o   = way_ind_t'({Ways{gen_req_i}});
                sram_we_o    = gen_we_i;
                sram_index_o = gen_index_i;
                sram_wdata_o = gen_pattern_i;
                if (gen_req_i && !gen_we_i) begin
                    push_src = GEN;
                end
            end
            OPERATE: begin
                // A BIST re-run request wins over any pending traffic.
                if (!bist_start_i) begin
                    if (lu_valid_i && (!fl_valid_i || rr == LU)) begin
                        lu_ready_o = 1'b1;
                    end else if (fl_valid_i) begin
                        fl_ready_o = 1'b1;
                    end
                end
                if (lu_ready_o) begin
                    sram_req_o   = lu_way_i;
                    sram_we_o    = lu_we_i;
                    sram_index_o = lu_index_i;
                    sram_wdata_o = lu_pattern_i;
                    if ((|lu_way_i) && !lu_we_i) begin
                        push_src = LU;
                    end
                end else if (fl_ready_o) begin
                    sram_req_o   = fl_way_i;
                    sram_we_o    = fl_we_i;
                    sram_index_o = fl_index_i;
                    sram_wdata_o = fl_pattern_i;
                    if ((|fl_way_i) && !fl_we_i) begin
                        push_src = FL;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= START;
            rr          <= LU;
            init_done_o <= 1'b0;
            spm_ways_o  <= '0;
        end else begin
            case (state)
                START: begin
                    if (gen_valid_o) begin
                        state <= BIST;
                    end
                end
                BIST: begin
                    if (gen_eoc_i) begin
                        spm_ways_o  <= gen_bist_res_i;
                        init_done_o <= 1'b1;
                        state       <= OPERATE;
                    end
                end
                OPERATE: begin
                    if (bist_start_i) begin
                        init_done_o <= 1'b0;
                        state       <= QUIESCE;
                    end
                    if (lu_ready_o) begin
                        rr <= FL;
                    end else if (fl_ready_o) begin
                        rr <= LU;
                    end
                end
                QUIESCE: begin
                    if (pipe_empty) begin
                        state <= START;
                    end
                end
                default: state <= START;
            endcase
        end
    end

    axi_llc_tag_rsp_pipe #(
        .SramLatency(SramLatency)
    ) i_rsp_pipe (
        .clk     (clk_i),
        .rst     (rst_i),
        .push_src(push_src),
        .head_src(head_src),
        .empty   (pipe_empty)
    );

    // Reset drops in-flight responses in the same cycle it is asserted.
    assign gen_rsp_valid_o = !rst_i && (head_src == GEN);
    assign lu_rsp_valid_o  = !rst_i && (head_src == LU);
    assign fl_rsp_valid_o  = !rst_i && (head_src == FL);

endmodule

// File: tb/tb_axi_llc_tag_port_sched.sv
// Directed bench for the tag-port scheduler: BIST sequencing, arbitration,
// response routing, BIST re-run and reset during traffic.
module tb_axi_llc_tag_port_sched;
    import axi_llc_pkg::*;

    typedef logic [3:0] way_t;
    typedef logic [3:0] idx_t;
    typedef logic [5:0] pat_t;

    localparam llc_cfg_t Cfg = '{SetAssociativity: 32'd4, IndexLength: 32'd4};

    logic clk = 1'b0;
    logic rst;
    logic bist_start;
    logic gen_valid, gen_ready, gen_req, gen_we, gen_eoc, gen_rsp_valid;
    idx_t gen_index;
    pat_t gen_pattern;
    way_t gen_bist_res;
    logic lu_valid, lu_we, lu_ready, lu_rsp_valid;
    way_t lu_way;
    idx_t lu_index;
    pat_t lu_pattern;
    logic fl_valid, fl_we, fl_ready, fl_rsp_valid;
    way_t fl_way;
    idx_t fl_index;
    pat_t fl_pattern;
    way_t sram_req;
    logic sram_we;
    idx_t sram_index;
    pat_t sram_wdata;
    logic init_done;
    way_t spm_ways;

    int checks = 0;
    int errors = 0;
    tag_src_e sb[$];

    always #5 clk = ~clk;

    axi_llc_tag_port_sched #(
        .Cfg        (Cfg),
        .way_ind_t  (way_t),
        .index_t    (idx_t),
        .pattern_t  (pat_t),
        .SramLatency(1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bist_start_i   (bist_start),
        .gen_valid_o    (gen_valid),
        .gen_ready_i    (gen_ready),
        .gen_req_i      (gen_req),
        .gen_we_i       (gen_we),
        .gen_index_i    (gen_index),
        .gen_pattern_i  (gen_pattern),
        .gen_eoc_i      (gen_eoc),
        .gen_bist_res_i (gen_bist_res),
        .gen_rsp_valid_o(gen_rsp_valid),
        .lu_valid_i     (lu_valid),
        .lu_we_i        (lu_we),
        .lu_ready_o     (lu_ready),
        .lu_way_i       (lu_way),
        .lu_index_i     (lu_index),
        .lu_pattern_i   (lu_pattern),
        .lu_rsp_valid_o (lu_rsp_valid),
        .fl_valid_i     (fl_valid),
        .fl_we_i        (fl_we),
        .fl_ready_o     (fl_ready),
        .fl_way_i       (fl_way),
        .fl_index_i     (fl_index),
        .fl_pattern_i   (fl_pattern),
        .fl_rsp_valid_o (fl_rsp_valid),
        .sram_req_o     (sram_req),
        .sram_we_o      (sram_we),
        .sram_index_o   (sram_index),
        .sram_wdata_o   (sram_wdata),
        .init_done_o    (init_done),
        .spm_ways_o     (spm_ways)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the source expected to answer next cycle, clock once, then
    // compare all three response valids against the popped entry.
    task automatic step(input tag_src_e nxt);
        tag_src_e e;
        sb.push_back(nxt);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gen_rsp_valid", gen_rsp_valid, e == GEN);
        chk("lu_rsp_valid", lu_rsp_valid, e == LU);
        chk("fl_rsp_valid", fl_rsp_valid, e == FL);
    endtask

    initial begin
        rst = 1'b1; bist_start = 1'b0;
        gen_ready = 1'b1; gen_req = 1'b0; gen_we = 1'b0; gen_eoc = 1'b0;
        gen_index = '0; gen_pattern = '0; gen_bist_res = '0;
        lu_valid = 1'b0; lu_we = 1'b0; lu_way = '0; lu_index = '0; lu_pattern = '0;
        fl_valid = 1'b0; fl_we = 1'b0; fl_way = '0; fl_index = '0; fl_pattern = '0;

        step(NONE);
        step(NONE);
        chk("reset_init_done", init_done, 1'b0);
        chk("reset_spm_ways", spm_ways, 4'h0);
        chk("reset_sram_req", sram_req, 4'h0);

        // START: lookup stalls, generator is kicked off.
        rst = 1'b0;
        lu_valid = 1'b1; lu_way = 4'hf; lu_index = 4'h1;
        #1;
        chk("start_gen_valid", gen_valid, 1'b1);
        chk("start_lu_stall", lu_ready, 1'b0);
        step(NONE);
        chk("bist_gen_valid_low", gen_valid, 1'b0);

        // BIST: generator owns the port.
        gen_req = 1'b1; gen_we = 1'b0; gen_index = 4'h3;
        #1;
        chk("bist_rd_req", sram_req, 4'hf);
        chk("bist_rd_index", sram_index, 4'h3);
        chk("bist_rd_we", sram_we, 1'b0);
        chk("bist_lu_stall", lu_ready, 1'b0);
        step(GEN);
        gen_we = 1'b1; gen_pattern = 6'h2a;
        #1;
        chk("bist_wr_we", sram_we, 1'b1);
        chk("bist_wr_data", sram_wdata, 6'h2a);
        step(NONE);
        gen_req = 1'b0; gen_we = 1'b0; gen_eoc = 1'b1; gen_bist_res = 4'h0;
        #1;
        chk("eoc_init_done_low", init_done, 1'b0);
        step(NONE);
        gen_eoc = 1'b0;
        chk("eoc_init_done", init_done, 1'b1);
        chk("eoc_spm_ways", spm_ways, 4'h0);

        // Both requesters reading every cycle: grants alternate starting at lookup.
        fl_valid = 1'b1; fl_way = 4'h1; fl_index = 4'h7;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_lu_ready", lu_ready, (i % 2) == 0);
            chk("rr_fl_ready", fl_ready, (i % 2) == 1);
            chk("rr_sram_req", sram_req, ((i % 2) == 0) ? 4'hf : 4'h1);
            step(((i % 2) == 0) ? LU : FL);
        end

        // Lookup write: drives the port, no response.
        fl_valid = 1'b0;
        lu_we = 1'b1; lu_index = 4'h5; lu_way = 4'h2;
        #1;
        chk("luw_ready", lu_ready, 1'b1);
        chk("luw_req", sram_req, 4'h2);
        chk("luw_index", sram_index, 4'h5);
        chk("luw_we", sram_we, 1'b1);
        step(NONE);

        // Zero way mask: granted but silent.
        lu_we = 1'b0; lu_way = 4'h0;
        #1;
        chk("zero_way_ready", lu_ready, 1'b1);
        chk("zero_way_req", sram_req, 4'h0);
        step(NONE);

        // BIST re-run right after a lookup read.
        lu_way = 4'h8;
        #1;
        chk("pre_bist_lu_ready", lu_ready, 1'b1);
        step(LU);
        bist_start = 1'b1; fl_valid = 1'b1;
        #1;
        chk("bist_start_lu_ready", lu_ready, 1'b0);
        chk("bist_start_fl_ready", fl_ready, 1'b0);
        chk("bist_start_req", sram_req, 4'h0);
        step(NONE);
        bist_start = 1'b0;
        #1;
        chk("quiesce_init_done", init_done, 1'b0);
        chk("quiesce_lu_ready", lu_ready, 1'b0);
        chk("quiesce_gen_valid", gen_valid, 1'b0);
        step(NONE);
        chk("rerun_gen_valid", gen_valid, 1'b1);
        chk("rerun_init_done", init_done, 1'b0);
        chk("rerun_lu_ready", lu_ready, 1'b0);
        bist_start = 1'b1;
        step(NONE);
        bist_start = 1'b0;
        chk("rerun_bist_gen_valid", gen_valid, 1'b0);
        chk("rerun_bist_init_done", init_done, 1'b0);
        gen_eoc = 1'b1; gen_bist_res = 4'h4;
        step(NONE);
        gen_eoc = 1'b0;
        chk("rerun_init_done_high", init_done, 1'b1);
        chk("rerun_spm_ways", spm_ways, 4'h4);

        // Pointer sits on flush after the last lookup grant.
        #1;
        chk("post_fl_ready", fl_ready, 1'b1);
        chk("post_lu_ready_low", lu_ready, 1'b0);
        step(FL);
        chk("post_lu_ready", lu_ready, 1'b1);
        step(LU);
        chk("spm_ways_held", spm_ways, 4'h4);

        // Reset right behind a flush read grant drops its response.
        lu_valid = 1'b0;
        #1;
        chk("rst_fl_ready", fl_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_fl_rsp_dropped", fl_rsp_valid, 1'b0);
        fl_valid = 1'b0; gen_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("after_rst_fl_rsp", fl_rsp_valid, 1'b0);
        chk("after_rst_init_done", init_done, 1'b0);
        chk("after_rst_spm_ways", spm_ways, 4'h0);
        chk("after_rst_gen_valid_nrdy", gen_valid, 1'b0);
        sb.delete();
        step(NONE);
        gen_ready = 1'b1;
        #1;
        chk("after_rst_gen_valid", gen_valid, 1'b1);
        step(NONE);
        chk("after_rst_bist_gen_valid", gen_valid, 1'b0);
        gen_eoc = 1'b1; gen_bist_res = 4'h0;
        step(NONE);
        gen_eoc = 1'b0;
        chk("final_init_done", init_done, 1'b1);
        chk("final_spm_ways", spm_ways, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
